// File: rtl/oculink_pkg.sv
// rtl/oculink_pkg.sv - shared state encoding and timing defaults for OCuLink link bring-up
// Purpose: state codes (also decoded by the status CSRs) and the 250 MHz PERST# hold default.
// Ports:   none (package).
package oculink_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DEBOUNCE   = 3'd1,
    ST_PERST_HOLD = 3'd2,
    ST_TRAIN      = 3'd3,
    ST_UP         = 3'd4,
    ST_FAIL       = 3'd5
  } state_t;

  // 100 ms of PERST# low at a 250 MHz block clock.
  localparam int unsigned PERST_HOLD_CYC_250MHZ = 25_000_000;

  // PERST# is released only while training or with the link up.
  function automatic logic perst_released(state_t s);
    return (s == ST_TRAIN) || (s == ST_UP);
  endfunction

endpackage

// File: rtl/oculink_perst_ctrl_if.sv
// rtl/oculink_perst_ctrl_if.sv - control/status bundle between a port sequencer and its environment
// Purpose: groups cable/link inputs and PERST#/status outputs of oculink_perst_ctrl.
// Ports:   cprsnt, enable, link_up, sw_reset_req (to sequencer);
//          perst_n, link_ready, link_fail, state, retry_cnt (from sequencer).
interface oculink_perst_ctrl_if;
  import oculink_pkg::*;

  logic       cprsnt;
  logic       enable;
  logic       link_up;
  logic       sw_reset_req;
  logic       perst_n;
  logic       link_ready;
  logic       link_fail;
  state_t     state;
  logic [3:0] retry_cnt;

  modport master (
    output cprsnt, enable, link_up, sw_reset_req,
    input  perst_n, link_ready, link_fail, state, retry_cnt
  );

  modport slave (
    input  cprsnt, enable, link_up, sw_reset_req,
    output perst_n, link_ready, link_fail, state, retry_cnt
  );

endinterface

// File: rtl/cdc_sync2.sv
// rtl/cdc_sync2.sv - generic two-flop synchronizer for asynchronous level inputs
// Purpose: brings an asynchronous strap into the clk domain.
// Ports:   clk, rst (async, active-high, loads RST_VAL), d (async in), q (synchronized out).
module cdc_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/oculink_perst_ctrl.sv
// rtl/oculink_perst_ctrl.sv - OCuLink PERST# bring-up sequencer with debounce, retry and failure
// Purpose: debounces cable-present, holds PERST#, releases it, waits for link-up, retries on timeout.
// Ports:   sys_clk, sys_rst (async, active-high);
//          bus.slave: cprsnt (async, active-low), enable, link_up, sw_reset_req in;
//                     perst_n, link_ready, link_fail, state, retry_cnt out.
module oculink_perst_ctrl
  import oculink_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC     = 1000,
  parameter int unsigned PERST_HOLD_CYC   = PERST_HOLD_CYC_250MHZ,
  parameter int unsigned LINK_TIMEOUT_CYC = 250_000_000,
  parameter int unsigned MAX_RETRY        = 3,
  parameter int unsigned CNT_W            = 32
) (
  input logic             sys_clk,
  input logic             sys_rst,
  oculink_perst_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST     = CNT_W'(PERST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(LINK_TIMEOUT_CYC - 1);
  localparam logic [3:0]       RETRY_LIMIT   = 4'(MAX_RETRY);

  logic             cprsnt_sync;
  logic             present;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       retry_q, retry_d;
  logic             perst_n_q, link_ready_q, link_fail_q;

  // Synchronizer resets to "cable absent" (cprsnt is active-low).
  cdc_sync2 #(.RST_VAL(1'b1)) u_cprsnt_sync (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (bus.cprsnt),
    .q   (cprsnt_sync)
  );

  assign present = ~cprsnt_sync;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (state_q != ST_IDLE && (!bus.enable || !present)) begin
      // Cable loss or disable overrides everything, including a software request.
      state_d = ST_IDLE;
      retry_d = '0;
    end else if (bus.sw_reset_req &&
                 (state_q inside {ST_DEBOUNCE, ST_PERST_HOLD, ST_TRAIN, ST_UP})) begin
      state_d = ST_PERST_HOLD;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.enable && present) state_d = ST_DEBOUNCE;
        end
        ST_DEBOUNCE: begin
          if (cnt_q == DEBOUNCE_LAST) state_d = ST_PERST_HOLD;
        end
        ST_PERST_HOLD: begin
          if (cnt_q == HOLD_LAST) state_d = ST_TRAIN;
        end
        ST_TRAIN: begin
          // link_up is tested first so it wins over a coincident timeout.
          if (bus.link_up) begin
            state_d = ST_UP;
            retry_d = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q == RETRY_LIMIT) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_PERST_HOLD;
              retry_d = retry_q + 4'd1;
            end
          end
        end
        ST_UP: begin
          if (!bus.link_up) state_d = ST_PERST_HOLD;
        end
        ST_FAIL: begin
          if (bus.sw_reset_req) begin
            state_d = ST_IDLE;
            retry_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          retry_d = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they switch with state, glitch-free.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      retry_q      <= '0;
      perst_n_q    <= 1'b0;
      link_ready_q <= 1'b0;
      link_fail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
      retry_q      <= retry_d;
      perst_n_q    <= perst_released(state_d);
      link_ready_q <= (state_d == ST_UP);
      link_fail_q  <= (state_d == ST_FAIL);
    end
  end

  assign bus.state      = state_q;
  assign bus.retry_cnt  = retry_q;
  assign bus.perst_n    = perst_n_q;
  assign bus.link_ready = link_ready_q;
  assign bus.link_fail  = link_fail_q;

endmodule

// File: tb/tb_oculink_perst_ctrl.sv
// tb/tb_oculink_perst_ctrl.sv - scoreboard bench for oculink_perst_ctrl
module tb_oculink_perst_ctrl;

  typedef struct {
    int         edge_no;
    logic [9:0] snap;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   edge_no = 0;
  bit   done = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  string name_q[$];

  oculink_perst_ctrl_if bus();

  oculink_perst_ctrl #(
    .DEBOUNCE_CYC     (4),
    .PERST_HOLD_CYC   (10),
    .LINK_TIMEOUT_CYC (20),
    .MAX_RETRY        (2),
    .CNT_W            (32)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 1;

  function automatic logic [9:0] mk(int st, bit pn, bit lr, bit lf, int rc);
    logic [2:0] s;
    logic [3:0] r;
    s = 3'(st);
    r = 4'(rc);
    return {s, pn, lr, lf, r};
  endfunction

  task automatic push(input int e, input logic [9:0] s, input string nm);
    exp_t x;
    x.edge_no = e;
    x.snap    = s;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  task automatic wait_edge(input int e);
    while (edge_no < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stimulus: expected output snapshots (with the edge they must appear on) are queued up front.
  initial begin
    int b;
    rst = 1'b1;
    bus.cprsnt = 1'b1;
    bus.enable = 1'b0;
    bus.link_up = 1'b0;
    bus.sw_reset_req = 1'b0;
    push(-1, mk(0, 0, 0, 0, 0), "reset_state");
    wait_edge(3);
    rst = 1'b0;
    bus.enable = 1'b1;

    // Normal bring-up, link drop in UP, surprise removal in UP.
    b = 5;
    push(b + 3,  mk(1, 0, 0, 0, 0), "bringup_debounce");
    push(b + 7,  mk(2, 0, 0, 0, 0), "bringup_hold");
    push(b + 17, mk(3, 1, 0, 0, 0), "bringup_perst_rise");
    push(b + 23, mk(4, 1, 1, 0, 0), "bringup_link_ready");
    push(b + 31, mk(2, 0, 0, 0, 0), "linkdrop_hold");
    push(b + 41, mk(3, 1, 0, 0, 0), "linkdrop_train");
    push(b + 46, mk(4, 1, 1, 0, 0), "linkdrop_up_again");
    push(b + 53, mk(0, 0, 0, 0, 0), "removal_idle");
    wait_edge(b);      bus.cprsnt = 1'b0;
    wait_edge(b + 22); bus.link_up = 1'b1;
    wait_edge(b + 30); bus.link_up = 1'b0;
    wait_edge(b + 45); bus.link_up = 1'b1;
    wait_edge(b + 50); bus.cprsnt = 1'b1;
    wait_edge(b + 55); bus.link_up = 1'b0;

    // Glitch of three synchronized cycles.
    b = 65;
    push(b + 3, mk(1, 0, 0, 0, 0), "glitch_debounce");
    push(b + 6, mk(0, 0, 0, 0, 0), "glitch_idle");
    wait_edge(b);     bus.cprsnt = 1'b0;
    wait_edge(b + 3); bus.cprsnt = 1'b1;

    // Timeout/retry to FAIL, sw reset, link_up on timeout cycle, sw reset with removal.
    b = 75;
    push(b + 3,   mk(1, 0, 0, 0, 0), "to_debounce");
    push(b + 7,   mk(2, 0, 0, 0, 0), "to_hold0");
    push(b + 17,  mk(3, 1, 0, 0, 0), "to_train0");
    push(b + 37,  mk(2, 0, 0, 0, 1), "to_hold1");
    push(b + 47,  mk(3, 1, 0, 0, 1), "to_train1");
    push(b + 67,  mk(2, 0, 0, 0, 2), "to_hold2");
    push(b + 77,  mk(3, 1, 0, 0, 2), "to_train2");
    push(b + 97,  mk(5, 0, 0, 1, 2), "to_fail");
    push(b + 106, mk(0, 0, 0, 0, 0), "fail_swreset_idle");
    push(b + 107, mk(1, 0, 0, 0, 0), "re_debounce");
    push(b + 111, mk(2, 0, 0, 0, 0), "re_hold");
    push(b + 121, mk(3, 1, 0, 0, 0), "re_train");
    push(b + 141, mk(2, 0, 0, 0, 1), "re_hold_retry");
    push(b + 151, mk(3, 1, 0, 0, 1), "re_train_retry");
    push(b + 171, mk(4, 1, 1, 0, 0), "linkup_on_timeout");
    push(b + 183, mk(0, 0, 0, 0, 0), "sw_and_removal_idle");
    wait_edge(b);       bus.cprsnt = 1'b0;
    wait_edge(b + 105); bus.sw_reset_req = 1'b1;
    wait_edge(b + 106); bus.sw_reset_req = 1'b0;
    wait_edge(b + 170); bus.link_up = 1'b1;
    wait_edge(b + 180); bus.cprsnt = 1'b1;
    wait_edge(b + 182); bus.sw_reset_req = 1'b1;
    wait_edge(b + 183); bus.sw_reset_req = 1'b0; bus.link_up = 1'b0;
    wait_edge(b + 190); bus.sw_reset_req = 1'b1;
    wait_edge(b + 191); bus.sw_reset_req = 1'b0;

    // Async reset mid-PERST_HOLD, restart after release, enable drop, removal in DEBOUNCE.
    b = 275;
    push(b + 3,  mk(1, 0, 0, 0, 0), "rst_debounce");
    push(b + 7,  mk(2, 0, 0, 0, 0), "rst_hold");
    push(b + 12, mk(0, 0, 0, 0, 0), "async_reset");
    push(b + 18, mk(1, 0, 0, 0, 0), "post_rst_debounce");
    push(b + 22, mk(2, 0, 0, 0, 0), "post_rst_hold");
    push(b + 26, mk(0, 0, 0, 0, 0), "enable_low_idle");
    push(b + 31, mk(1, 0, 0, 0, 0), "enable_high_debounce");
    push(b + 34, mk(0, 0, 0, 0, 0), "removal_in_debounce");
    wait_edge(b);      bus.cprsnt = 1'b0;
    wait_edge(b + 12); rst = 1'b1;
    wait_edge(b + 15); rst = 1'b0;
    wait_edge(b + 25); bus.enable = 1'b0;
    wait_edge(b + 30); bus.enable = 1'b1;
    wait_edge(b + 31); bus.cprsnt = 1'b1;
    wait_edge(b + 45);
    done = 1'b1;
  end

  // Monitor: every change of the output bundle pops one expectation and compares it.
  initial begin
    logic [9:0] prev;
    logic [9:0] cur;
    exp_t       x;
    string      nm;
    prev = 10'h3ff;
    forever begin
      @(negedge clk);
      if (done) break;
      cur = {bus.state, bus.perst_n, bus.link_ready, bus.link_fail, bus.retry_cnt};
      if (cur !== prev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change: got %b at edge %0d, required no change", cur, edge_no);
        end else begin
          x  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (cur !== x.snap || (x.edge_no >= 0 && x.edge_no != edge_no)) begin
            fails++;
            $display("FAIL %s: got %b at edge %0d, required %b at edge %0d",
                     nm, cur, edge_no, x.snap, x.edge_no);
          end
        end
        prev = cur;
      end
    end
    while (exp_q.size() != 0) begin
      x  = exp_q.pop_front();
      nm = name_q.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: got no change, required %b at edge %0d", nm, x.snap, x.edge_no);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oculink_perst_ctrl.md
# oculink_perst_ctrl

Link bring-up sequencer for one OCuLink PCIe port. It debounces the cable-present strap and holds the downstream device in PERST# for the mandated interval. It then releases PERST#, waits for the PCIe core to report link-up, and retries or declares failure on timeout. One instance sits beside each oculink_port in system_top and drives that port's PERST# pin.

## Interface
- DEBOUNCE_CYC, 1000: cycles cprsnt must stay asserted before the sequence starts (≥1)
- PERST_HOLD_CYC, 25_000_000: PERST# low time, 100 ms at 250 MHz (≥1)
- LINK_TIMEOUT_CYC, 250_000_000: maximum wait for link_up after PERST# release (≥1)
- MAX_RETRY, 3: PERST# re-pulses allowed before FAIL (0..15)
- CNT_W, 32: width of the shared interval counter; must hold every *_CYC value
- sys_clk  in  1  block clock
- sys_rst  in  1  reset: asynchronous, active-high
- cprsnt  in  1  OCuLink cable-present, active-low, asynchronous to sys_clk
- enable  in  1  level; low forces IDLE
- link_up  in  1  PCIe core link-up, synchronous to sys_clk
- sw_reset_req  in  1  single-cycle pulse requesting a fresh PERST# cycle
- perst_n  out  1  PERST# to the device; reset 0
- link_ready  out  1  high only in UP; reset 0
- link_fail  out  1  high only in FAIL; reset 0
- state  out  3  current state code; reset IDLE
- retry_cnt  out  4  retries consumed; reset 0

## Operation
- cprsnt passes through a 2-flop synchronizer. present = NOT synchronized cprsnt.
- A single CNT_W counter is cleared on every state change and increments otherwise.
- State codes: IDLE=0, DEBOUNCE=1, PERST_HOLD=2, TRAIN=3, UP=4, FAIL=5. Codes 6 and 7 go to IDLE.
- IDLE: when enable and present, go to DEBOUNCE.
- DEBOUNCE: when present drops, go to IDLE. When cnt == DEBOUNCE_CYC-1, go to PERST_HOLD.
- PERST_HOLD: when cnt == PERST_HOLD_CYC-1, go to TRAIN.
- TRAIN:
  - link_up → UP, and retry_cnt clears.
  - cnt == LINK_TIMEOUT_CYC-1 with retry_cnt == MAX_RETRY → FAIL.
  - cnt == LINK_TIMEOUT_CYC-1 otherwise → PERST_HOLD, retry_cnt+1.
  - If link_up and the timeout occur in the same cycle, link_up wins.
- UP: when link_up drops, go to PERST_HOLD. retry_cnt stays 0.
- FAIL: sw_reset_req → IDLE, retry_cnt clears. Otherwise stay (sticky).
- Global priority, highest first:
  1. (!enable || !present) in any state other than IDLE → IDLE, retry_cnt clears.
  2. sw_reset_req in DEBOUNCE/PERST_HOLD/TRAIN/UP → PERST_HOLD, retry_cnt clears.
  3. The per-state rules above.
- sw_reset_req in IDLE is ignored.
- perst_n is 1 only in TRAIN and UP.
- perst_n, link_ready and link_fail are flops loaded from the next-state decode. They change on the same edge as state and never glitch.

## Timing
- Cable-insert latency, counting edge 1 as the first sys_clk edge that samples cprsnt low:
  - present high after edge 2
  - DEBOUNCE entered at edge 3
  - PERST_HOLD entered at edge 3+DEBOUNCE_CYC
  - perst_n rises at edge 3+DEBOUNCE_CYC+PERST_HOLD_CYC
- A cprsnt glitch shorter than DEBOUNCE_CYC cycles after synchronization returns the block to IDLE. The debounce restarts from 0.
- Cable removal: perst_n falls 3 edges after cprsnt is first sampled high, in any state.
- link_up → link_ready: 1 edge.
- TRAIN lasts at most LINK_TIMEOUT_CYC cycles.
- Each retry gives PERST# a full PERST_HOLD_CYC low pulse.
- Reset asserted mid-sequence: all outputs return to their reset values immediately (asynchronously). The synchronizer flops clear to "not present".
- Reset release: the first evaluation occurs on the next edge.

## Structure
- Package oculink_pkg holds:
  - the 3-bit state encoding constants (shared with status CSRs)
  - the PERST hold default for 250 MHz
- Sub-module cdc_sync2: generic 2-flop synchronizer with asynchronous active-high reset and a reset-value parameter. Reusable for other async straps.
- The rest is one FSM + counter + output-flop process.

## Test plan
All tests use DEBOUNCE_CYC=4, PERST_HOLD_CYC=10, LINK_TIMEOUT_CYC=20, MAX_RETRY=2.
- Normal bring-up: cprsnt low at edge 1, enable=1 → perst_n rises at edge 17. link_up at edge 22 → link_ready=1 at edge 23, state=4.
- Glitch: cprsnt low for 3 synchronized cycles, then high → state returns to 0, perst_n stays 0.
- Timeout/retry: link_up never asserts → three PERST_HOLD pulses of 10 cycles each. retry_cnt goes 0→1→2, then state=5, link_fail=1, perst_n=0. sw_reset_req then gives state=0, retry_cnt=0.
- Surprise removal in UP: cprsnt high → perst_n=0 and link_ready=0 3 edges later, state=0.
- Link drop in UP: link_up low → state=2, perst_n=0 next edge. After 10 cycles, perst_n=1 and retry_cnt=0.
- Simultaneous events:
  - sw_reset_req and cable removal on the same edge → IDLE, not PERST_HOLD.
  - link_up on the timeout cycle → UP.
  - sys_rst pulse mid-PERST_HOLD → all outputs 0 asynchronously.
